// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch FIFO between fetch (PC + imem) and the
// IF/ID register. Holds {pc, instr} pairs in a circular buffer and drains
// them to decode with a valid/ready handshake. flush (branch redirect)
// synchronously discards every buffered entry.
// Optional build macro FETCH_QUEUE_BYPASS_EN: when defined, an empty queue
// forwards in_* straight to out_* in the same cycle. If decode takes the
// pair in that cycle, it is never written into the queue.
module fetch_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] r_memPc    [DEPTH];
  logic [XLEN-1:0] r_memInstr [DEPTH];
  logic [AW-1:0]   r_wrPtr;
  logic [AW-1:0]   r_rdPtr;
  logic [CW-1:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_bypass;

  // Status flags and handshake qualifiers. in_ready depends on registered
  // occupancy only, so there is no combinational path from out_ready.
  always_comb begin
    w_full   = (r_count == CW'(DEPTH));
    w_empty  = (r_count == '0);
    in_ready = !w_full;
    full     = w_full;
    empty    = w_empty;
    count    = r_count;
`ifdef FETCH_QUEUE_BYPASS_EN
    // The forward path is not gated by flush; only the push is.
    w_bypass  = w_empty && in_valid && out_ready;
    out_valid = w_empty ? in_valid : 1'b1;
    out_pc    = w_empty ? in_pc    : r_memPc[r_rdPtr];
    out_instr = w_empty ? in_instr : r_memInstr[r_rdPtr];
    w_pop     = !w_empty && out_ready;
`else
    w_bypass  = 1'b0;
    out_valid = !w_empty;
    out_pc    = w_empty ? '0 : r_memPc[r_rdPtr];
    out_instr = w_empty ? '0 : r_memInstr[r_rdPtr];
    w_pop     = !w_empty && out_ready;
`endif
    w_push    = in_valid && !w_full && !w_bypass;
  end

  // Storage write; the array is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_memPc[r_wrPtr]    <= in_pc;
      r_memInstr[r_wrPtr] <= in_instr;
    end
  end

  // Pointers and occupancy. Flush wins over push/pop, and pointers wrap
  // naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus randomized traffic for fetch_queue,
// compared each cycle against a queue-based reference model.
module tb_fetch_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            inValid;
  logic            inReady;
  logic [XLEN-1:0] inPc;
  logic [XLEN-1:0] inInstr;
  logic            outValid;
  logic            outReady;
  logic [XLEN-1:0] outPc;
  logic [XLEN-1:0] outInstr;
  logic [$clog2(DEPTH):0] count;
  logic            full;
  logic            empty;

  int totalChecks = 0;
  int badChecks   = 0;

  logic [63:0] modelQ [$];
  logic [31:0] nextPc;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in_pc     (inPc),
    .in_instr  (inInstr),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_pc    (outPc),
    .out_instr (outInstr),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Compare every output against the model, then advance the model using
  // the inputs that the DUT samples at the coming rising edge.
  task automatic modelCheckAndStep();
    logic        expValid;
    logic [31:0] expPc;
    logic [31:0] expInstr;
    logic        accept;
    logic        consume;
    logic        direct;
    int          n;
    n = modelQ.size();
    if (n != 0) begin
      expValid = 1'b1;
      expPc    = modelQ[0][63:32];
      expInstr = modelQ[0][31:0];
    end else begin
`ifdef FETCH_QUEUE_BYPASS_EN
      expValid = inValid;
      expPc    = inPc;
      expInstr = inInstr;
`else
      expValid = 1'b0;
      expPc    = '0;
      expInstr = '0;
`endif
    end
    checkOutput("count",     64'(count),    64'(n));
    checkOutput("full",      64'(full),     64'(n == DEPTH));
    checkOutput("empty",     64'(empty),    64'(n == 0));
    checkOutput("in_ready",  64'(inReady),  64'(n < DEPTH));
    checkOutput("out_valid", 64'(outValid), 64'(expValid));
    checkOutput("out_pc",    64'(outPc),    64'(expPc));
    checkOutput("out_instr", 64'(outInstr), 64'(expInstr));

    if (flush) begin
      modelQ.delete();
    end else begin
      accept  = inValid && (n < DEPTH);
      consume = expValid && outReady;
`ifdef FETCH_QUEUE_BYPASS_EN
      direct  = (n == 0) && accept && outReady;
`else
      direct  = 1'b0;
`endif
      if (!direct) begin
        if (consume && n != 0) void'(modelQ.pop_front());
        if (accept) modelQ.push_back({inPc, inInstr});
      end
    end
  endtask

  // Drive one cycle of inputs; outputs are checked at the falling edge and
  // the call returns 1 time unit after the following rising edge.
  task automatic applyStimulus(input logic fl, input logic iv,
                               input logic [31:0] pc, input logic [31:0] ins,
                               input logic ordy);
    flush    = fl;
    inValid  = iv;
    inPc     = pc;
    inInstr  = ins;
    outReady = ordy;
    @(negedge clk);
    modelCheckAndStep();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
    inPc = '0; inInstr = '0;

    // Test 1: reset held for two cycles, then three pushes
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 64'(outValid), 64'd0);
    checkOutput("rst_count",     64'(count),    64'd0);
    checkOutput("rst_in_ready",  64'(inReady),  64'd1);
    checkOutput("rst_empty",     64'(empty),    64'd1);
    checkOutput("rst_out_pc",    64'(outPc),    64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 32'(i * 4), 32'h13, 0);
    checkOutput("t1_count",  64'(count), 64'd3);
    checkOutput("t1_out_pc", 64'(outPc), 64'h0);

    // Test 2: fill to full, held fifth pair, ordered drain
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 32'h10 + 32'(i * 4), 32'hA0 + 32'(i), 0);
    checkOutput("t2_full",     64'(full),    64'd1);
    checkOutput("t2_in_ready", 64'(inReady), 64'd0);
    applyStimulus(0, 1, 32'h20, 32'hA4, 0);
    checkOutput("t2_held_count", 64'(count), 64'd4);
    checkOutput("t2_head_pc",    64'(outPc), 64'h10);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t2_empty", 64'(empty), 64'd1);

    // Test 3: simultaneous push/pop across pointer wrap
    applyStimulus(0, 1, 32'h200, 32'hB0, 0);
    applyStimulus(0, 1, 32'h204, 32'hB1, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 32'h208 + 32'(i * 4), 32'hB2 + 32'(i), 1);
    checkOutput("t3_count",   64'(count), 64'd2);
    checkOutput("t3_head_pc", 64'(outPc), 64'h218);

    // Test 4: flush together with a push drops the pair
    applyStimulus(0, 1, 32'h21C, 32'hC0, 0);
    checkOutput("t4_pre_count", 64'(count), 64'd3);
    applyStimulus(1, 1, 32'h40, 32'hC1, 0);
    checkOutput("t4_count",     64'(count),    64'd0);
    checkOutput("t4_out_valid", 64'(outValid), 64'd0);
    applyStimulus(0, 1, 32'h80, 32'hC2, 0);
    checkOutput("t4_out_pc", 64'(outPc), 64'h80);

    // Test 5: asynchronous reset between edges while count=2
    applyStimulus(0, 1, 32'h84, 32'hC3, 0);
    inValid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t5_count",     64'(count),    64'd0);
    checkOutput("t5_out_valid", 64'(outValid), 64'd0);
    modelQ.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

`ifdef FETCH_QUEUE_BYPASS_EN
    // Test 6: same-cycle forward when empty
    flush = 1'b0; inValid = 1'b1; inPc = 32'h100; inInstr = 32'hD0; outReady = 1'b1;
    #1;
    checkOutput("t6_fwd_pc",    64'(outPc),    64'h100);
    checkOutput("t6_fwd_valid", 64'(outValid), 64'd1);
    applyStimulus(0, 1, 32'h100, 32'hD0, 1);
    checkOutput("t6_count0", 64'(count), 64'd0);
    applyStimulus(0, 1, 32'h104, 32'hD1, 0);
    checkOutput("t6_count1", 64'(count), 64'd1);
    checkOutput("t6_head",   64'(outPc), 64'h104);
`endif

    // Randomized traffic against the model
    nextPc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      logic fl, iv, ordy;
      fl   = ($urandom_range(0, 15) == 0);
      iv   = $urandom_range(0, 1);
      ordy = $urandom_range(0, 2) != 0;
      applyStimulus(fl, iv, nextPc, $urandom, ordy);
      if (iv) nextPc = nextPc + 32'd4;
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

  // Global time guard so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL timeout got=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
